image_pipe_pack: RTL and testbench
==================================

# image_pipe_pack

Parametrised width-packing stage for the image pipeline. It accepts narrow pixel beats on the slave side (`is_*`) and emits words of `RATIO` lanes on the master side (`im_*`), using the pipeline's valid/end/busy handshake. End-of-frame flushes a partial word, which is zero-padded and marked with a lane-keep mask. It sits between a narrow pixel source and wide downstream processing or memory-write stages, and generalises the fixed DW_IN/DW_OUT pipe stage.

## Interface
- `DW_IN`, default 8: input beat width, ≥1.
- `RATIO`, default 4: input beats per output word, ≥1. `DW_OUT = DW_IN*RATIO` is a localparam, not overridable.
- `LSB_FIRST`, default 1: 1 = first beat of a word lands in bits [DW_IN-1:0]; 0 = first beat lands in the top lane.
- `FCW`, default 16: frame counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `is_data_in` in DW_IN: input beat.
- `is_valid_in` in 1: input beat present.
- `is_end_in` in 1: last beat of frame; qualified by `is_valid_in`.
- `is_busy_out` out 1: stage cannot accept a beat this cycle.
- `im_data_out` out DW_OUT: packed word.
- `im_valid_out` out 1: output word present.
- `im_end_out` out 1: word contains the frame's last beat.
- `im_keep_out` out RATIO: bit i = lane i holds real data.
- `im_busy_in` in 1: downstream stall.
- `stat_frame_cnt` out FCW: count of frames completed on the output.

## Operation
- **Input accept:** `is_valid_in && !is_busy_out` on a rising edge. The beat is written into lane `lane_idx`, then `lane_idx` increments.
- **Output transfer:** `im_valid_out && !im_busy_in`. While `im_valid_out && im_busy_in`, `im_data_out`, `im_end_out` and `im_keep_out` are held stable.
- **Busy:** `is_busy_out = im_valid_out && im_busy_in`. This is a combinational path from `im_busy_in`, by design.
- **Word completion:** occurs on an accepted beat with `lane_idx == RATIO-1` or `is_end_in == 1`.
  - The word, end flag and keep mask move to the output register.
  - `lane_idx` returns to 0 and the accumulator clears to 0.
- **Keep mask:** lanes 0..k set, where k is the lane index of the completing beat. Unwritten lanes read as 0.
- **LSB_FIRST=0:** lane i maps to bits [(RATIO-i)*DW_IN-1 : (RATIO-i-1)*DW_IN]. `im_keep_out` bit i still refers to logical lane i (beat order), not bit position.
- **RATIO=1:** behaves as a registered pass-through. `im_keep_out` is always 1 on a valid word.
- **Frame counter:** `stat_frame_cnt` increments on each output transfer with `im_end_out = 1`. It wraps from 2^FCW-1 to 0.
- **Reset (including mid-frame):** the partial accumulator and any pending output word are discarded. There is no frame recovery; the next accepted beat starts lane 0.
- **Reset values:** `im_valid_out` = 0, `im_end_out` = 0, `im_data_out` = 0, `im_keep_out` = 0, `stat_frame_cnt` = 0, `is_busy_out` = 0, `lane_idx` = 0.

## Timing
- **Latency:** the completing beat accepted at edge t gives `im_valid_out` = 1 from edge t (visible the following cycle).
- **Zero-bubble reload:** an output transfer and a new completion in the same cycle load the new word. `im_valid_out` stays 1 with no bubble.
- **Full throughput:** with `im_busy_in` low, one beat per cycle in and one word per RATIO cycles out.
- **Stall on a partial word:** with `im_busy_in` high and the output register full, `is_busy_out` is high and no beats are accepted. This applies even if the accumulator is partial.
- **Simultaneous end and last lane:** `is_end_in` on lane RATIO-1 gives a full keep mask, `im_end_out` = 1, and no extra word.
- **Consecutive frames:** a one-beat frame directly after `im_end_out` is legal and produces keep = 1 (lane 0 only).

## Structure
- **Package `image_pipe_pkg`:**
  - `lane_idx_t` sized `$clog2(RATIO)` (minimum 1 bit).
  - Function `keep_mask(k)` returning lanes 0..k set.
  - Shared handshake constants for all image_pipe stages.
- **Sub-module `image_pipe_out_reg`:** the output holding register (data/end/keep, valid, busy generation). It is reusable by later image_pipe stages.
- **Top:** the accumulator, `lane_idx` counter and frame counter stay in `image_pipe_pack`.

## Test plan
1. DW_IN=8, RATIO=4, LSB_FIRST=1; beats 0x11,0x22,0x33,0x44 (end on last), no stall → one word 0x44332211, keep=0xF, `im_end_out` = 1, `stat_frame_cnt` = 1.
2. Frame of 6 beats 0x01..0x06 → word 0x04030201 with keep=0xF, end=0; then word 0x00000605 with keep=0x3, end=1.
3. LSB_FIRST=0; beats 0xAA,0xBB with end → 0xAABB0000, keep=0x3.
4. Hold `im_busy_in`=1 for 5 cycles with the output register full → `is_busy_out` = 1, output word stable, no beats accepted. After release, continuous input produces no lost or duplicated beats (scoreboard over 1000 random beats with random stalls).
5. Assert `rst_n` low after 2 beats of a frame → all outputs 0 immediately. The next frame 0x01..0x04 packs from lane 0 as 0x04030201.
6. FCW=4; 17 one-beat frames → counter wraps, reading 1 after the 17th end transfer.

Source files
------------

// File: rtl/image_pipe_pkg.sv
// Shared types, handshake constants and helpers for the image_pipe stages.
package image_pipe_pkg;

    // Widest lane count any image_pipe stage may be built with.
    localparam int KEEP_MAX = 64;

    localparam logic HS_ASSERT   = 1'b1;
    localparam logic HS_DEASSERT = 1'b0;

    typedef struct packed {
        logic valid;
        logic last;
    } hs_flags_t;

    // Lane index width: a single lane still needs one bit to hold index 0.
    function automatic int lane_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    function automatic logic [KEEP_MAX-1:0] keep_mask(input int k);
        logic [KEEP_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < KEEP_MAX; i++) begin
            if (i <= k) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/image_pipe_pack_if.sv
// Valid/end/busy handshake bundle of the width-packing stage.
// slave = the packing stage itself, master = the environment around it.
interface image_pipe_pack_if #(
    parameter int DW_IN = 8,
    parameter int RATIO = 4
);
    localparam int DW_OUT = DW_IN * RATIO;

    logic [DW_IN-1:0]  is_data_in;
    logic              is_valid_in;
    logic              is_end_in;
    logic              is_busy_out;
    logic [DW_OUT-1:0] im_data_out;
    logic              im_valid_out;
    logic              im_end_out;
    logic [RATIO-1:0]  im_keep_out;
    logic              im_busy_in;

    modport slave (
        input  is_data_in,
        input  is_valid_in,
        input  is_end_in,
        output is_busy_out,
        output im_data_out,
        output im_valid_out,
        output im_end_out,
        output im_keep_out,
        input  im_busy_in
    );

    modport master (
        output is_data_in,
        output is_valid_in,
        output is_end_in,
        input  is_busy_out,
        input  im_data_out,
        input  im_valid_out,
        input  im_end_out,
        input  im_keep_out,
        output im_busy_in
    );

endinterface

// File: rtl/image_pipe_out_reg.sv
// Output holding register for image_pipe stages: holds data/end/keep while
// downstream stalls and back-pressures the upstream side.
module image_pipe_out_reg
    import image_pipe_pkg::*;
#(
    parameter int DW = 32,
    parameter int KW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic          end_i,
    input  logic [KW-1:0] keep_i,
    input  logic          busy_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic          end_o,
    output logic [KW-1:0] keep_o,
    output logic          busy_o,
    output logic          xfer_o
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q,  data_d;
    logic          end_q,   end_d;
    logic [KW-1:0] keep_q,  keep_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= HS_DEASSERT;
            data_q  <= '0;
            end_q   <= 1'b0;
            keep_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            end_q   <= end_d;
            keep_q  <= keep_d;
        end
    end

    // A load only arrives when the register is empty or draining this cycle,
    // so loading over a transfer gives the zero-bubble reload.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        end_d   = end_q;
        keep_d  = keep_q;
        if (load_i) begin
            valid_d = HS_ASSERT;
            data_d  = data_i;
            end_d   = end_i;
            keep_d  = keep_i;
        end else if (xfer_o) begin
            valid_d = HS_DEASSERT;
        end
    end

    assign xfer_o  = valid_q && !busy_i;
    assign busy_o  = valid_q && busy_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign end_o   = end_q;
    assign keep_o  = keep_q;

endmodule

// File: rtl/image_pipe_pack.sv
// Width-packing stage: gathers RATIO narrow beats into one wide word,
// flushing a zero-padded partial word with a keep mask at end of frame.
module image_pipe_pack
    import image_pipe_pkg::*;
#(
    parameter int DW_IN     = 8,
    parameter int RATIO     = 4,
    parameter int LSB_FIRST = 1,
    parameter int FCW       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    image_pipe_pack_if.slave  bus,
    output logic [FCW-1:0]    stat_frame_cnt
);

    localparam int DW_OUT = DW_IN * RATIO;
    localparam int LW     = lane_w(RATIO);

    typedef logic [LW-1:0] lane_idx_t;

    lane_idx_t         lane_q, lane_d;
    logic [DW_OUT-1:0] acc_q,  acc_d;
    logic [FCW-1:0]    cnt_q,  cnt_d;

    logic              busy_w;
    logic              accept_w;
    logic              complete_w;
    logic              xfer_w;
    logic [DW_OUT-1:0] word_w;
    logic [RATIO-1:0]  keep_w;

    assign accept_w   = bus.is_valid_in && !busy_w;
    assign complete_w = accept_w && ((lane_q == lane_idx_t'(RATIO - 1)) || bus.is_end_in);
    assign keep_w     = RATIO'(keep_mask(int'(lane_q)));

    // Accumulator with the incoming beat merged into its lane's bit slot.
    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
            localparam int POS = (LSB_FIRST != 0) ? gi : (RATIO - 1 - gi);
            assign word_w[POS*DW_IN +: DW_IN] =
                (accept_w && (lane_q == lane_idx_t'(gi))) ? bus.is_data_in
                                                           : acc_q[POS*DW_IN +: DW_IN];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
        end else begin
            lane_q <= lane_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        lane_d = lane_q;
        acc_d  = acc_q;
        if (complete_w) begin
            lane_d = '0;
            acc_d  = '0;
        end else if (accept_w) begin
            lane_d = lane_q + 1'b1;
            acc_d  = word_w;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (xfer_w && bus.im_end_out) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign stat_frame_cnt = cnt_q;

    image_pipe_out_reg #(
        .DW (DW_OUT),
        .KW (RATIO)
    ) u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (complete_w),
        .data_i  (word_w),
        .end_i   (bus.is_end_in),
        .keep_i  (keep_w),
        .busy_i  (bus.im_busy_in),
        .valid_o (bus.im_valid_out),
        .data_o  (bus.im_data_out),
        .end_o   (bus.im_end_out),
        .keep_o  (bus.im_keep_out),
        .busy_o  (busy_w),
        .xfer_o  (xfer_w)
    );

    assign bus.is_busy_out = busy_w;

endmodule

// File: tb/tb_image_pipe_pack.sv
// Scoreboard bench for image_pipe_pack: three instances cover LSB-first,
// MSB-first, and a one-lane pass-through with a narrow frame counter.
module tb_image_pipe_pack;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [3:0]  keep;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    exp_t ea, eb, ec;

    logic [15:0] stat_a, stat_b;
    logic [3:0]  stat_c;

    image_pipe_pack_if #(.DW_IN(8), .RATIO(4)) bus_a ();
    image_pipe_pack_if #(.DW_IN(8), .RATIO(4)) bus_b ();
    image_pipe_pack_if #(.DW_IN(8), .RATIO(1)) bus_c ();

    image_pipe_pack #(.DW_IN(8), .RATIO(4), .LSB_FIRST(1), .FCW(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a.slave), .stat_frame_cnt(stat_a));
    image_pipe_pack #(.DW_IN(8), .RATIO(4), .LSB_FIRST(0), .FCW(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b.slave), .stat_frame_cnt(stat_b));
    image_pipe_pack #(.DW_IN(8), .RATIO(1), .LSB_FIRST(1), .FCW(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(bus_c.slave), .stat_frame_cnt(stat_c));

    // Output monitors: a transfer at the next rising edge is decided by
    // signals that are already stable on the falling edge.
    always @(negedge clk) begin
        if (rst_n && bus_a.im_valid_out && !bus_a.im_busy_in) begin
            total_cnt++;
            if (q_a.size() == 0) begin
                $display("FAIL mon_a unexpected word: got data=%h keep=%h end=%b, required no word",
                         bus_a.im_data_out, bus_a.im_keep_out, bus_a.im_end_out);
            end else begin
                ea = q_a.pop_front();
                if (bus_a.im_data_out !== ea.data || bus_a.im_end_out !== ea.last || bus_a.im_keep_out !== ea.keep)
                    $display("FAIL mon_a word: got data=%h keep=%h end=%b, required data=%h keep=%h end=%b",
                             bus_a.im_data_out, bus_a.im_keep_out, bus_a.im_end_out, ea.data, ea.keep, ea.last);
                else
                    pass_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus_b.im_valid_out && !bus_b.im_busy_in) begin
            total_cnt++;
            if (q_b.size() == 0) begin
                $display("FAIL mon_b unexpected word: got data=%h keep=%h end=%b, required no word",
                         bus_b.im_data_out, bus_b.im_keep_out, bus_b.im_end_out);
            end else begin
                eb = q_b.pop_front();
                if (bus_b.im_data_out !== eb.data || bus_b.im_end_out !== eb.last || bus_b.im_keep_out !== eb.keep)
                    $display("FAIL mon_b word: got data=%h keep=%h end=%b, required data=%h keep=%h end=%b",
                             bus_b.im_data_out, bus_b.im_keep_out, bus_b.im_end_out, eb.data, eb.keep, eb.last);
                else
                    pass_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus_c.im_valid_out && !bus_c.im_busy_in) begin
            total_cnt++;
            if (q_c.size() == 0) begin
                $display("FAIL mon_c unexpected word: got data=%h keep=%h end=%b, required no word",
                         bus_c.im_data_out, bus_c.im_keep_out, bus_c.im_end_out);
            end else begin
                ec = q_c.pop_front();
                if ({24'h0, bus_c.im_data_out} !== ec.data || bus_c.im_end_out !== ec.last ||
                    {3'b000, bus_c.im_keep_out} !== ec.keep)
                    $display("FAIL mon_c word: got data=%h keep=%h end=%b, required data=%h keep=%h end=%b",
                             bus_c.im_data_out, bus_c.im_keep_out, bus_c.im_end_out, ec.data, ec.keep, ec.last);
                else
                    pass_cnt++;
            end
        end
    end

    task automatic drive(input int sel, input logic v, input logic [7:0] d, input logic e);
        case (sel)
            0: begin bus_a.is_valid_in = v; bus_a.is_data_in = d; bus_a.is_end_in = e; end
            1: begin bus_b.is_valid_in = v; bus_b.is_data_in = d; bus_b.is_end_in = e; end
            default: begin bus_c.is_valid_in = v; bus_c.is_data_in = d; bus_c.is_end_in = e; end
        endcase
    endtask

    function automatic logic get_busy(input int sel);
        case (sel)
            0: return bus_a.is_busy_out;
            1: return bus_b.is_busy_out;
            default: return bus_c.is_busy_out;
        endcase
    endfunction

    task automatic push_exp(input int sel, input logic [31:0] d, input logic l, input logic [3:0] k);
        exp_t x;
        x.data = d;
        x.last = l;
        x.keep = k;
        case (sel)
            0: q_a.push_back(x);
            1: q_b.push_back(x);
            default: q_c.push_back(x);
        endcase
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_beat(input int sel, input logic [7:0] d, input logic e);
        logic busy;
        int n;
        n = 0;
        drive(sel, 1'b1, d, e);
        do begin
            @(negedge clk);
            busy = get_busy(sel);
            @(posedge clk);
            #1;
            n++;
        end while (busy && n < 2000);
        if (busy) begin
            total_cnt++;
            $display("FAIL send_timeout sel=%0d: beat %h still refused, required acceptance", sel, d);
        end
        drive(sel, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_a.size() + q_b.size() + q_c.size()) != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        total_cnt++;
        if ((q_a.size() + q_b.size() + q_c.size()) != 0)
            $display("FAIL drain: got %0d words outstanding, required 0",
                     q_a.size() + q_b.size() + q_c.size());
        else
            pass_cnt++;
    endtask

    task automatic check_stat(input string name, input logic [15:0] got, input logic [15:0] exp);
        total_cnt++;
        if (got !== exp) $display("FAIL %s: got %0d, required %0d", name, got, exp);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        drive(2, 1'b0, 8'h00, 1'b0);
        bus_a.im_busy_in = 1'b0;
        bus_b.im_busy_in = 1'b0;
        bus_c.im_busy_in = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (bus_a.im_valid_out !== 1'b0 || bus_a.im_data_out !== 32'h0 || bus_a.im_keep_out !== 4'h0 ||
            bus_a.im_end_out !== 1'b0 || bus_a.is_busy_out !== 1'b0 || stat_a !== 16'h0)
            $display("FAIL reset_a: got valid=%b data=%h keep=%h end=%b busy=%b cnt=%0d, required all 0",
                     bus_a.im_valid_out, bus_a.im_data_out, bus_a.im_keep_out, bus_a.im_end_out,
                     bus_a.is_busy_out, stat_a);
        else pass_cnt++;
        total_cnt++;
        if (bus_b.im_valid_out !== 1'b0 || bus_b.im_data_out !== 32'h0 || stat_b !== 16'h0 ||
            bus_c.im_valid_out !== 1'b0 || bus_c.im_keep_out !== 1'b0 || stat_c !== 4'h0)
            $display("FAIL reset_bc: got valid_b=%b data_b=%h cnt_b=%0d valid_c=%b keep_c=%b cnt_c=%0d, required all 0",
                     bus_b.im_valid_out, bus_b.im_data_out, stat_b, bus_c.im_valid_out, bus_c.im_keep_out, stat_c);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_pack();
        push_exp(0, 32'h44332211, 1'b1, 4'hF);
        send_beat(0, 8'h11, 1'b0);
        send_beat(0, 8'h22, 1'b0);
        send_beat(0, 8'h33, 1'b0);
        send_beat(0, 8'h44, 1'b1);
        drain();
        check_stat("basic_frame_cnt", stat_a, 16'd1);
    endtask

    task automatic test_multi_word();
        push_exp(0, 32'h04030201, 1'b0, 4'hF);
        push_exp(0, 32'h00000605, 1'b1, 4'h3);
        push_exp(0, 32'h00000099, 1'b1, 4'h1);
        for (int i = 1; i <= 6; i++) send_beat(0, 8'(i), i == 6);
        send_beat(0, 8'h99, 1'b1);
        drain();
        check_stat("multi_frame_cnt", stat_a, 16'd3);
    endtask

    task automatic test_msb_first();
        push_exp(1, 32'hAABB0000, 1'b1, 4'h3);
        push_exp(1, 32'h01020304, 1'b1, 4'hF);
        send_beat(1, 8'hAA, 1'b0);
        send_beat(1, 8'hBB, 1'b1);
        for (int i = 1; i <= 4; i++) send_beat(1, 8'(i), i == 4);
        drain();
        check_stat("msb_frame_cnt", stat_b, 16'd2);
    endtask

    task automatic test_stall();
        bus_a.im_busy_in = 1'b1;
        push_exp(0, 32'hD4D3D2D1, 1'b0, 4'hF);
        push_exp(0, 32'h88776655, 1'b1, 4'hF);
        send_beat(0, 8'hD1, 1'b0);
        send_beat(0, 8'hD2, 1'b0);
        send_beat(0, 8'hD3, 1'b0);
        send_beat(0, 8'hD4, 1'b0);
        drive(0, 1'b1, 8'h55, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total_cnt++;
            if (bus_a.is_busy_out !== 1'b1) $display("FAIL stall_busy cycle %0d: got %b, required 1", i, bus_a.is_busy_out);
            else pass_cnt++;
            total_cnt++;
            if (bus_a.im_valid_out !== 1'b1 || bus_a.im_data_out !== 32'hD4D3D2D1 || bus_a.im_keep_out !== 4'hF)
                $display("FAIL stall_hold cycle %0d: got valid=%b data=%h keep=%h, required valid=1 data=d4d3d2d1 keep=f",
                         i, bus_a.im_valid_out, bus_a.im_data_out, bus_a.im_keep_out);
            else pass_cnt++;
            @(posedge clk);
            #1;
        end
        bus_a.im_busy_in = 1'b0;
        send_beat(0, 8'h55, 1'b0);
        send_beat(0, 8'h66, 1'b0);
        send_beat(0, 8'h77, 1'b0);
        send_beat(0, 8'h88, 1'b1);
        drain();
        check_stat("stall_frame_cnt", stat_a, 16'd4);
    endtask

    bit rand_done;

    task automatic test_random_stream();
        logic [31:0] acc;
        logic [7:0]  d;
        logic        e;
        int          lane;
        int          ends;
        acc = 32'h0;
        lane = 0;
        ends = 0;
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    d = 8'($urandom);
                    e = ($urandom_range(0, 7) == 0) || (i == 999);
                    acc = acc | (32'(d) << (8 * lane));
                    if (lane == 3 || e) begin
                        push_exp(0, acc, e, 4'((1 << (lane + 1)) - 1));
                        if (e) ends++;
                        acc = 32'h0;
                        lane = 0;
                    end else begin
                        lane++;
                    end
                    send_beat(0, d, e);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    bus_a.im_busy_in = ($urandom_range(0, 3) == 0);
                end
                bus_a.im_busy_in = 1'b0;
            end
        join
        drain();
        check_stat("random_frame_cnt", stat_a, 16'(4 + ends));
    endtask

    task automatic test_frame_wrap();
        for (int i = 0; i < 15; i++) begin
            push_exp(2, 32'(i + 1), 1'b1, 4'h1);
            send_beat(2, 8'(i + 1), 1'b1);
        end
        drain();
        check_stat("wrap_cnt_15", {12'h0, stat_c}, 16'd15);
        for (int i = 15; i < 17; i++) begin
            push_exp(2, 32'(i + 1), 1'b1, 4'h1);
            send_beat(2, 8'(i + 1), 1'b1);
        end
        drain();
        check_stat("wrap_cnt_17", {12'h0, stat_c}, 16'd1);
    endtask

    task automatic test_mid_frame_reset();
        push_exp(0, 32'hA4A3A2A1, 1'b0, 4'hF);
        for (int i = 1; i <= 4; i++) send_beat(0, 8'hA0 + 8'(i), 1'b0);
        send_beat(0, 8'hB1, 1'b0);
        send_beat(0, 8'hB2, 1'b0);
        drain();
        bus_a.im_busy_in = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (bus_a.im_valid_out !== 1'b0 || bus_a.im_data_out !== 32'h0 || bus_a.im_keep_out !== 4'h0 ||
            bus_a.im_end_out !== 1'b0 || bus_a.is_busy_out !== 1'b0 || stat_a !== 16'h0)
            $display("FAIL midreset_outputs: got valid=%b data=%h keep=%h end=%b busy=%b cnt=%0d, required all 0",
                     bus_a.im_valid_out, bus_a.im_data_out, bus_a.im_keep_out, bus_a.im_end_out,
                     bus_a.is_busy_out, stat_a);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        bus_a.im_busy_in = 1'b0;
        @(posedge clk);
        #1;
        push_exp(0, 32'h04030201, 1'b1, 4'hF);
        for (int i = 1; i <= 4; i++) send_beat(0, 8'(i), i == 4);
        drain();
        check_stat("midreset_frame_cnt", stat_a, 16'd1);
    endtask

    initial begin
        test_reset();
        test_basic_pack();
        test_multi_word();
        test_msb_first();
        test_stall();
        test_random_stream();
        test_frame_wrap();
        test_mid_frame_reset();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
